bitserial_alu_sequencer: RTL and testbench

//  Sequences one structuralBitSlice to perform a full WIDTH-bit ALU operation, one bit per clock, LSB first.
//  - Latches operands on a start handshake and feeds them to the slice bit by bit.
//  - Chains the slice carryout back into carryin through a register.
//  - Shifts sum bits into a result register and reports result, flags and done.
//  - Sits between the ALU command source and a single shared slice; the slice stays combinational and outside this block.

---
 rtl/bitserial_alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_bitserial_alu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_alu_sequencer.sv
// Bit-serial ALU sequencer: drives one external combinational bit slice LSB-first
// for WIDTH cycles, chaining carry through a register and collecting sum bits.
module bitserial_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [2:0]       slice_control,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carryin,
    input  logic             slice_sum,
    input  logic             slice_carryout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   acc_shift;
    logic               final_ovf;

    assign acc_shift = WIDTH'({slice_sum, acc_q} >> 1);

    // On the final bit a_sh/b_sh[0] hold the original operand MSBs.
    always_comb begin
        unique case (op_q)
            OP_ADD:  final_ovf = (a_sh_q[0] == b_sh_q[0]) && (slice_sum != a_sh_q[0]);
            OP_SUB:  final_ovf = (a_sh_q[0] != b_sh_q[0]) && (slice_sum != a_sh_q[0]);
            default: final_ovf = 1'b0;
        endcase
    end

    // NOTE: every always_comb target gets its hold value first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = opa;
                    b_sh_d  = opb;
                    op_d    = op;
                    cnt_d   = '0;
                    carry_d = (op == OP_SUB);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_shift;
                    carry_d = slice_carryout;
                    a_sh_d  = a_sh_q >> 1;
                    b_sh_d  = b_sh_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d     = S_DONE;
                        result_d    = acc_shift;
                        carry_out_d = slice_carryout;
                        overflow_d  = final_ovf;
                        zero_d      = (acc_shift == '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            op_q        <= 3'b000;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign ready         = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign result        = result_q;
    assign carry_out     = carry_out_q;
    assign overflow      = overflow_q;
    assign zero          = zero_q;
    assign slice_control = op_q;
    assign slice_a       = busy & a_sh_q[0];
    assign slice_b       = busy & b_sh_q[0];
    assign slice_carryin = busy & carry_q;

endmodule

// File: tb/tb_bitserial_alu_sequencer.sv
// Bench for bitserial_alu_sequencer (WIDTH=8) with a behavioural bit slice,
// directed vectors, randomized runs against an arithmetic model, and corner sequences.
module tb_bitserial_alu_sequencer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic [2:0]       slice_control;
    logic             slice_a;
    logic             slice_b;
    logic             slice_carryin;
    logic             slice_sum;
    logic             slice_carryout;

    int checks   = 0;
    int failures = 0;

    bitserial_alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op             (op),
        .opa            (opa),
        .opb            (opb),
        .abort          (abort),
        .ready          (ready),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .carry_out      (carry_out),
        .overflow       (overflow),
        .zero           (zero),
        .slice_control  (slice_control),
        .slice_a        (slice_a),
        .slice_b        (slice_b),
        .slice_carryin  (slice_carryin),
        .slice_sum      (slice_sum),
        .slice_carryout (slice_carryout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural one-bit slice: 000 add, 001 a+~b+cin, 110 xor.
    always_comb begin
        logic bb;
        bb = (slice_control == 3'b001) ? ~slice_b : slice_b;
        if (slice_control == 3'b110) begin
            slice_sum      = slice_a ^ slice_b;
            slice_carryout = 1'b0;
        end else begin
            slice_sum      = slice_a ^ bb ^ slice_carryin;
            slice_carryout = (slice_a & bb) | (slice_a & slice_carryin) | (bb & slice_carryin);
        end
    end

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
    } vec_t;

    function automatic vec_t model(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        vec_t       e;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] nb;
        nb = ~b;
        case (o)
            3'b000:  full = {1'b0, a} + {1'b0, b};
            3'b001:  full = {1'b0, a} + {1'b0, nb} + 1;
            default: full = {1'b0, a ^ b};
        endcase
        e.op = o;
        e.a  = a;
        e.b  = b;
        e.r  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
        e.z  = (e.r == 0);
        if (o == 3'b000)
            e.v = (a[WIDTH-1] == b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
        else if (o == 3'b001)
            e.v = (a[WIDTH-1] != b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
        else
            e.v = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done is seen; n = ticks taken, or -1 if the bound expires.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_dones(input int len, output int cnt);
        cnt = 0;
        for (int k = 0; k < len; k++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    task automatic run_and_check(input string tag, input vec_t e);
        int n;
        launch(e.op, e.a, e.b);
        check({tag, " busy"}, busy, 1);
        check({tag, " ctrl"}, slice_control, e.op);
        check({tag, " slice_a"}, slice_a, e.a[0]);
        wait_done(n);
        check({tag, " latency"}, n, WIDTH);
        check({tag, " result"}, result, e.r);
        check({tag, " carry"}, carry_out, e.c);
        check({tag, " ovf"}, overflow, e.v);
        check({tag, " zero"}, zero, e.z);
        tick();
        check({tag, " done_pulse"}, done, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int   n;
        int   nd;
        vec_t e;
        logic [2:0] ro;

        vecs[0] = '{3'b000, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{3'b110, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op    = 3'b000;
        opa   = '0;
        opb   = '0;
        #12;
        check("rst ready", ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst carry", carry_out, 0);
        check("rst ovf", overflow, 0);
        check("rst zero", zero, 1);
        check("rst slice_ab", {slice_a, slice_b, slice_carryin}, 0);
        check("rst ctrl", slice_control, 0);
        #10 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);
        check("idle slice_ab", {slice_a, slice_b, slice_carryin}, 0);
        check("idle ctrl", slice_control, 3'b110);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       ro = 3'b000;
                1:       ro = 3'b001;
                default: ro = 3'b110;
            endcase
            e = model(ro, WIDTH'($urandom), WIDTH'($urandom));
            run_and_check($sformatf("rnd%0d", i), e);
        end

        // Start re-pulsed during RUN is ignored.
        launch(3'b000, 8'h12, 8'h34);
        tick();
        tick();
        op = 3'b001; opa = 8'hFF; opb = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("restart latency", n + 3, WIDTH);
        check("restart result", result, 8'h46);
        tick();

        // Back-to-back: start held in DONE.
        launch(3'b000, 8'h01, 8'h02);
        wait_done(n);
        check("b2b first latency", n, WIDTH);
        op = 3'b001; opa = 8'h50; opb = 8'h20; start = 1'b1;
        check("b2b done in DONE", done, 1);
        tick();
        start = 1'b0;
        check("b2b busy", busy, 1);
        check("b2b first result", result, 8'h03);
        wait_done(n);
        check("b2b spacing", n + 1, WIDTH + 1);
        check("b2b second result", result, 8'h30);
        tick();

        // Abort at RUN cycle 4.
        launch(3'b000, 8'h11, 8'h22);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", busy, 0);
        check("abort ready", ready, 1);
        count_dones(WIDTH + 2, nd);
        check("abort no done", nd, 0);
        check("abort result", result, 8'h30);

        // Abort coincident with the final bit.
        launch(3'b000, 8'h01, 8'h01);
        for (int k = 0; k < WIDTH - 1; k++) tick();
        check("abort_last busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_last done", done, 0);
        check("abort_last ready", ready, 1);
        check("abort_last result", result, 8'h30);

        // Abort while idle is ignored.
        abort = 1'b1;
        launch(3'b000, 8'h02, 8'h03);
        abort = 1'b0;
        check("idle_abort busy", busy, 1);
        wait_done(n);
        check("idle_abort latency", n, WIDTH);
        check("idle_abort result", result, 8'h05);
        tick();

        // Asynchronous reset mid-run.
        launch(3'b001, 8'h0F, 8'h0E);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst ready", ready, 1);
        check("mrst busy", busy, 0);
        check("mrst done", done, 0);
        check("mrst result", result, 0);
        check("mrst zero", zero, 1);
        check("mrst ctrl", slice_control, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(WIDTH + 2, nd);
        check("mrst no done", nd, 0);
        check("mrst ready after", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
